// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 sequence-detector family: state encoding,
// default pattern and pattern length.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [3:0] PATTERN_DEFAULT = 4'b1011;
    localparam int         PATTERN_LEN     = 4;
    localparam int         IDX_W           = $clog2(PATTERN_LEN);

endpackage

// File: rtl/seq_gen_1011_tx.sv
// Serial 1011 burst transmitter: emits `count` repetitions of PATTERN, MSB
// first, either concatenated or sharing the leading 1 with the previous tail.
module seq_gen_1011_tx
    import seq_det_pkg::*;
#(
    parameter logic [PATTERN_LEN-1:0] PATTERN = PATTERN_DEFAULT,
    parameter int                     CW      = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic          overlap,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          busy,
    output logic          done
);

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PATTERN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PATTERN_LEN - 2);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CW-1:0]    rep_reg, rep_next;
    logic             ovl_reg, ovl_next;
    logic             zero_pend_reg, zero_pend_next;
    logic             ser_out_reg, ser_out_next;
    logic             ser_valid_reg, ser_valid_next;
    logic             done_reg, done_next;
    logic             last_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            rep_reg       <= '0;
            ovl_reg       <= 1'b0;
            zero_pend_reg <= 1'b0;
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rep_reg       <= rep_next;
            ovl_reg       <= ovl_next;
            zero_pend_reg <= zero_pend_next;
            ser_out_reg   <= ser_out_next;
            ser_valid_reg <= ser_valid_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rep_next       = rep_reg;
        ovl_next       = ovl_reg;
        zero_pend_next = 1'b0;
        last_bit       = 1'b0;

        case (state_reg)
            ST_SEND: begin
                if (idx_reg == '0) begin
                    rep_next = rep_reg - CW'(1);
                    if (rep_reg == CW'(1)) begin
                        last_bit   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = ovl_reg ? IDX_OVL : IDX_MSB;
                    end
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            default: ;
        endcase

        // A start landing on the final bit chains the next burst with no gap.
        if (start && ((state_reg == ST_IDLE) || last_bit)) begin
            if (count != '0) begin
                state_next = ST_SEND;
                idx_next   = IDX_MSB;
                rep_next   = count;
                ovl_next   = overlap;
            end else begin
                zero_pend_next = 1'b1;
            end
        end

        done_next      = last_bit | zero_pend_reg;
        ser_valid_next = (state_next == ST_SEND);
        ser_out_next   = ser_valid_next & PATTERN[idx_next];
    end

    assign ser_out   = ser_out_reg;
    assign ser_valid = ser_valid_reg;
    assign busy      = ser_valid_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_gen_1011_tx.sv
// Bench for seq_gen_1011_tx: queue-based stream model checked every cycle,
// table-driven bursts, hand-written corner sequences and random start traffic.
module tb_seq_gen_1011_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] count = '0;
    logic       overlap = 1'b0;
    logic       ser_out, ser_valid, busy, done;

    seq_gen_1011_tx #(.PATTERN(4'b1011), .CW(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .count     (count),
        .overlap   (overlap),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: remaining bits of the current burst
    bit   m_sq[$];
    logic m_valid = 1'b0, m_bit = 1'b0, m_done = 1'b0, m_zero_pend = 1'b0;
    logic [3:0] pat = 4'b1011;

    // per-sequence statistics
    int          j, nvalid, ndone, done_at, hits, nb;
    logic [3:0]  hist;
    logic [63:0] bits;

    typedef struct {
        logic [3:0]  cnt;
        logic        ovl;
        int          exp_len;
        int          exp_hits;
        logic        has_bits;
        logic [63:0] exp_bits;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sq.delete();
        m_valid = 1'b0;
        m_bit = 1'b0;
        m_done = 1'b0;
        m_zero_pend = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] c, input logic o);
        bit acc;
        acc = s && (m_sq.size() == 0);
        m_done = (m_valid && (m_sq.size() == 0)) || m_zero_pend;
        m_zero_pend = acc && (c == 0);
        if (acc) begin
            $display("start accepted count=%0d overlap=%0d t=%0t", c, o, $time);
            for (int r = 0; r < int'(c); r++)
                for (int i = 3; i >= 0; i--)
                    if (!(o && r > 0 && i == 3)) m_sq.push_back(pat[i]);
        end
        if (m_sq.size() > 0) begin
            m_valid = 1'b1;
            m_bit = m_sq.pop_front();
        end else begin
            m_valid = 1'b0;
            m_bit = 1'b0;
        end
    endtask

    task automatic clear_stats();
        j = 0; nvalid = 0; ndone = 0; done_at = -1; hits = 0; nb = 0;
        hist = '0; bits = '0;
    endtask

    // Call at a negedge: drives inputs, advances one cycle, samples at the next negedge.
    task automatic step(input logic s, input logic [3:0] c, input logic o);
        start = s; count = c; overlap = o;
        @(posedge clk);
        model_edge(s, c, o);
        @(negedge clk);
        check("outs{valid,out,busy,done}", {60'd0, ser_valid, ser_out, busy, done},
              {60'd0, m_valid, m_bit, m_valid, m_done});
        if (ser_valid) begin
            nvalid++;
            nb++;
            hist = {hist[2:0], ser_out};
            bits = {bits[62:0], ser_out};
            if (nb >= 4 && hist == 4'b1011) hits++;
        end
        if (done) begin
            if (done_at < 0) done_at = j;
            ndone++;
        end
        j++;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        while (ndone == 0 && j < budget) step(1'b0, 4'd0, 1'b0);
        check("done_seen", {63'd0, ndone != 0}, 64'd1);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{4'd2,  1'b0, 8,  2,  1'b1, 64'hBB};
        vecs[1] = '{4'd3,  1'b1, 10, 3,  1'b1, 64'h2DB};
        vecs[2] = '{4'd0,  1'b0, 0,  0,  1'b1, 64'h0};
        vecs[3] = '{4'd0,  1'b1, 0,  0,  1'b0, 64'h0};
        vecs[4] = '{4'd1,  1'b1, 4,  1,  1'b1, 64'hB};
        vecs[5] = '{4'd5,  1'b0, 20, 5,  1'b0, 64'h0};
        vecs[6] = '{4'd15, 1'b0, 60, 15, 1'b0, 64'h0};
        vecs[7] = '{4'd15, 1'b1, 46, 15, 1'b0, 64'h0};

        repeat (2) @(negedge clk);
        check("reset_outs", {60'd0, ser_valid, ser_out, busy, done}, 64'd0);
        reset_n = 1'b1;
        step(1'b0, 4'd0, 1'b0);

        // table-driven bursts
        for (int v = 0; v < 8; v++) begin
            clear_stats();
            step(1'b1, vecs[v].cnt, vecs[v].ovl);
            drain(80);
            $display("burst count=%0d overlap=%0d len=%0d hits=%0d done_at=%0d",
                     vecs[v].cnt, vecs[v].ovl, nvalid, hits, done_at);
            check("len", 64'(nvalid), 64'(vecs[v].exp_len));
            check("hits", 64'(hits), 64'(vecs[v].exp_hits));
            check("done_at", 64'(done_at), (vecs[v].cnt == 0) ? 64'd1 : 64'(vecs[v].exp_len));
            check("done_count", 64'(ndone), 64'd1);
            if (vecs[v].has_bits) check("bits", bits, vecs[v].exp_bits);
        end

        // start while busy is ignored
        clear_stats();
        step(1'b1, 4'd2, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 1'b1);
        drain(40);
        $display("busy_start len=%0d done_count=%0d", nvalid, ndone);
        check("busy_start_len", 64'(nvalid), 64'd8);
        check("busy_start_bits", bits, 64'hBB);
        check("busy_start_done", 64'(ndone), 64'd1);

        // back-to-back: second start sampled on the edge that raises done
        clear_stats();
        step(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b0);
        $display("back_to_back len=%0d done_count=%0d first_done=%0d", nvalid, ndone, done_at);
        check("b2b_len", 64'(nvalid), 64'd8);
        check("b2b_bits", bits, 64'hBB);
        check("b2b_done_count", 64'(ndone), 64'd2);
        check("b2b_first_done", 64'(done_at), 64'd4);

        // asynchronous reset mid-burst
        clear_stats();
        step(1'b1, 4'd2, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("rst_async", {60'd0, ser_valid, ser_out, busy, done}, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0);
        $display("reset_mid_burst done_after=%0d valid_after=%0d", ndone, nvalid);
        check("rst_no_done", 64'(ndone), 64'd0);
        check("rst_no_valid", 64'(nvalid), 64'd0);
        clear_stats();
        step(1'b1, 4'd1, 1'b0);
        drain(20);
        check("rst_recover_bits", bits, 64'hB);
        check("rst_recover_len", 64'(nvalid), 64'd4);

        // random start traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic       s, o;
            logic [3:0] c;
            s = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            o = 1'($urandom_range(0, 1));
            step(s, c, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
